// File: rtl/config_add_gate_ctrl.sv
// Clock-gating controller for an external adder: runs the low result bits gated
// (approximate) until a precise request arrives, then settles, serves, and re-gates when idle.
module config_add_gate_ctrl #(
  parameter int unsigned DATA_PATH_BITWIDTH = 32,
  parameter int unsigned CLKGATED_BITWIDTH  = 16,
  parameter int unsigned ADD_LAT            = 2,
  parameter int unsigned SWITCH_CYC         = 2,
  parameter int unsigned IDLE_LIMIT         = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_precise,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
  output logic                          in_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] add_a,
  output logic [DATA_PATH_BITWIDTH-1:0] add_b,
  output logic                          add_en,
  input  logic [DATA_PATH_BITWIDTH-1:0] add_c,
  output logic                          out_valid,
  output logic                          out_precise,
  output logic [DATA_PATH_BITWIDTH-1:0] out_c
);

  localparam int unsigned SW_W   = $clog2(SWITCH_CYC + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_LIMIT + 1);
  localparam logic [DATA_PATH_BITWIDTH-1:0] HIGH_MASK =
    {{(DATA_PATH_BITWIDTH - CLKGATED_BITWIDTH){1'b1}}, {CLKGATED_BITWIDTH{1'b0}}};

  typedef enum logic [1:0] {
    ST_GATED,
    ST_SWITCH,
    ST_PRECISE
  } state_e;

  typedef struct packed {
    logic valid;
    logic precise;
  } tag_t;

  state_e                   state_q, state_d;
  logic [SW_W-1:0]          sw_cnt_q, sw_cnt_d;
  logic [IDLE_W-1:0]        idle_cnt_q, idle_cnt_d;
  logic                     add_en_q;
  tag_t [ADD_LAT-1:0]       tag_q, tag_d;
  tag_t                     out_tag;
  logic                     accept;
  logic                     pipe_busy;

  assign add_a  = in_a;
  assign add_b  = in_b;
  assign add_en = add_en_q;
  assign accept = in_valid & in_ready;

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < int'(ADD_LAT); i++) pipe_busy = pipe_busy | tag_q[i].valid;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    sw_cnt_d   = sw_cnt_q;
    idle_cnt_d = idle_cnt_q;
    in_ready   = 1'b0;
    unique case (state_q)
      ST_GATED: begin
        in_ready   = !in_precise;
        sw_cnt_d   = '0;
        idle_cnt_d = '0;
        if (in_valid && in_precise) state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        if (sw_cnt_q == SW_W'(SWITCH_CYC - 1)) begin
          state_d    = ST_PRECISE;
          sw_cnt_d   = '0;
          idle_cnt_d = '0;
        end else begin
          sw_cnt_d = sw_cnt_q + 1'b1;
        end
      end
      ST_PRECISE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_W'(IDLE_LIMIT)) begin
          // Only re-gate once nothing precise can still be in the adder.
          if (!pipe_busy) state_d = ST_GATED;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_GATED;
    endcase
    if (rst) in_ready = 1'b0;
  end

  always_comb begin
    tag_d[0].valid   = accept;
    tag_d[0].precise = accept & in_precise;
    for (int i = 1; i < int'(ADD_LAT); i++) tag_d[i] = tag_q[i-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_GATED;
      sw_cnt_q   <= '0;
      idle_cnt_q <= '0;
      add_en_q   <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      sw_cnt_q   <= sw_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      add_en_q   <= (state_d != ST_GATED);
      tag_q      <= tag_d;
    end
  end

  assign out_tag     = tag_q[ADD_LAT-1];
  assign out_valid   = out_tag.valid;
  assign out_precise = out_tag.valid & out_tag.precise;

  always_comb begin
    out_c = '0;
    if (out_tag.valid) out_c = out_tag.precise ? add_c : (add_c & HIGH_MASK);
  end

endmodule

// File: tb/tb_config_add_gate_ctrl.sv
// Directed bench for config_add_gate_ctrl with a two-stage registered adder model
// standing in for the external adder.
module tb_config_add_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_precise;
  logic [31:0] in_a, in_b, add_a, add_b, add_c, out_c;
  logic        in_ready, add_en, out_valid, out_precise;
  logic [31:0] sum_q0, sum_q1;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    sum_q0 <= add_a + add_b;
    sum_q1 <= sum_q0;
  end
  assign add_c = sum_q1;

  config_add_gate_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_precise(in_precise),
    .in_a(in_a), .in_b(in_b), .in_ready(in_ready), .add_a(add_a), .add_b(add_b),
    .add_en(add_en), .add_c(add_c), .out_valid(out_valid),
    .out_precise(out_precise), .out_c(out_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_precise = 1'b0; in_a = '0; in_b = '0;
    repeat (2) tick();
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (add_en !== 1'b0) begin bad++; $display("FAIL rst_add_en got=%b want=0", add_en); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_c !== 32'h0) begin bad++; $display("FAIL rst_out_c got=%h want=0", out_c); end
    total++; if (out_precise !== 1'b0) begin bad++; $display("FAIL rst_out_precise got=%b want=0", out_precise); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b want=1", in_ready); end
    total++; if (add_en !== 1'b0) begin bad++; $display("FAIL post_rst_add_en got=%b want=0", add_en); end
    tick();
  endtask

  task automatic test_approx();
    in_valid = 1'b1; in_precise = 1'b0; in_a = 32'h0001_FFFF; in_b = 32'h0000_0001;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL approx_ready got=%b want=1", in_ready); end
    total++; if (add_en !== 1'b0) begin bad++; $display("FAIL approx_add_en0 got=%b want=0", add_en); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL approx_early_valid got=%b want=0", out_valid); end
    tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL approx_valid got=%b want=1", out_valid); end
    total++; if (out_c !== 32'h0002_0000) begin bad++; $display("FAIL approx_out_c got=%h want=00020000", out_c); end
    total++; if (out_precise !== 1'b0) begin bad++; $display("FAIL approx_tag got=%b want=0", out_precise); end
    total++; if (add_en !== 1'b0) begin bad++; $display("FAIL approx_add_en2 got=%b want=0", add_en); end
    tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || out_c !== 32'h0) begin
      bad++; $display("FAIL approx_after valid=%b c=%h want valid=0 c=0", out_valid, out_c);
    end
    tick();
  endtask

  task automatic test_switch();
    in_valid = 1'b1; in_precise = 1'b1; in_a = 32'h0000_1234; in_b = 32'h0000_0001;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sw_gated_ready got=%b want=0", in_ready); end
    for (int s = 0; s < 2; s++) begin
      tick();
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sw_cycle%0d_ready got=%b want=0", s, in_ready); end
      total++; if (add_en !== 1'b1) begin bad++; $display("FAIL sw_cycle%0d_add_en got=%b want=1", s, add_en); end
    end
    tick();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sw_accept_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sw_early_valid got=%b want=0", out_valid); end
    tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_c !== 32'h0000_1235 || out_precise !== 1'b1) begin
      bad++; $display("FAIL sw_result valid=%b c=%h tag=%b want 1/00001235/1", out_valid, out_c, out_precise);
    end
    tick();
  endtask

  task automatic test_idle();
    int hold_bad;
    in_valid = 1'b1; in_precise = 1'b1; in_a = 32'h5; in_b = 32'h6;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_accept_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    // Eight counted idle cycles plus the deciding cycle keep add_en high.
    hold_bad = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (add_en !== 1'b1) hold_bad++;
      tick();
    end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL idle_hold low_cycles=%0d want=0", hold_bad); end
    @(negedge clk);
    total++; if (add_en !== 1'b0) begin bad++; $display("FAIL idle_drop add_en=%b want=0", add_en); end
    tick();
    in_valid = 1'b1; in_precise = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_reenter_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    in_valid = 1'b1; in_precise = 1'b0; in_a = 32'h1; in_b = 32'h1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || add_en !== 1'b1) begin
      bad++; $display("FAIL idle_last_req ready=%b add_en=%b want 1/1", in_ready, add_en);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (add_en !== 1'b1) begin bad++; $display("FAIL idle_kept add_en=%b want=1", add_en); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_c [10];
    logic        exp_p [10];
    logic [31:0] a, b, s;
    for (int k = 0; k < 12; k++) begin
      if (k < 10) begin
        a = 32'h1357_9BDF + 32'h0101_0101 * k;
        b = 32'h0000_1111 + 32'h0000_0003 * k;
        s = a + b;
        exp_p[k] = (k % 2 == 0);
        exp_c[k] = exp_p[k] ? s : (s & 32'hFFFF_0000);
        in_valid = 1'b1; in_precise = exp_p[k]; in_a = a; in_b = b;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 10) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", k, in_ready); end
      end
      if (k >= 2) begin
        total++; if (out_valid !== 1'b1 || out_precise !== exp_p[k-2] || out_c !== exp_c[k-2]) begin
          bad++; $display("FAIL b2b_result[%0d] valid=%b tag=%b c=%h want 1/%b/%h",
                          k-2, out_valid, out_precise, out_c, exp_p[k-2], exp_c[k-2]);
        end
      end
      tick();
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail_valid got=%b want=0", out_valid); end
    tick();
  endtask

  task automatic test_wrap();
    in_valid = 1'b1; in_precise = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001;
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_c !== 32'h0 || out_precise !== 1'b1) begin
      bad++; $display("FAIL wrap_result valid=%b c=%h tag=%b want 1/00000000/1", out_valid, out_c, out_precise);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int waited;
    in_valid = 1'b0;
    waited = 0;
    while (add_en !== 1'b0 && waited < 40) begin
      tick();
      waited++;
    end
    total++; if (add_en !== 1'b0) begin bad++; $display("FAIL wait_gated add_en=%b after %0d cycles want=0", add_en, waited); end
    // Approximate result in flight when reset hits.
    in_valid = 1'b1; in_precise = 1'b0; in_a = 32'h0000_00F0; in_b = 32'h0000_000F;
    tick();
    in_precise = 1'b1; rst = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b0; in_precise = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || out_c !== 32'h0 || add_en !== 1'b0) begin
      bad++; $display("FAIL flight_drop valid=%b c=%h add_en=%b want 0/0/0", out_valid, out_c, add_en);
    end
    tick();
    // Reset during the second SWITCH cycle.
    in_valid = 1'b1; in_precise = 1'b1;
    tick();
    @(negedge clk);
    total++; if (add_en !== 1'b1) begin bad++; $display("FAIL mid_sw_add_en got=%b want=1", add_en); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; in_precise = 1'b0;
    @(negedge clk);
    total++; if (add_en !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL sw_rst add_en=%b valid=%b ready=%b want 0/0/1", add_en, out_valid, in_ready);
    end
    tick();
    @(negedge clk);
    total++; if (add_en !== 1'b0) begin bad++; $display("FAIL sw_rst_stay add_en=%b want=0", add_en); end
    tick();
  endtask

  initial begin
    test_reset();
    test_approx();
    test_switch();
    test_idle();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_add_gate_ctrl.md
CONFIG_ADD_GATE_CTRL -- requirements
Module: config_add_gate_ctrl

Interface
REQ-001 Parameter DATA_PATH_BITWIDTH, default 32: operand/result width.
REQ-002 Parameter CLKGATED_BITWIDTH, default 16: low bits gated in approximate mode.
REQ-003 Parameter ADD_LAT, default 2: adder cycles from operand capture to result.
REQ-004 Parameter SWITCH_CYC, default 2: enable settle cycles on entry to precise mode.
REQ-005 Parameter IDLE_LIMIT, default 8: idle cycles in PRECISE before gating.
REQ-006 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1  operation request.
REQ-009 in_precise  in  1  1 = full-precision add, 0 = approximate add.
REQ-010 in_a, in_b  in  DATA_PATH_BITWIDTH  operands.
REQ-011 in_ready  out  1  request accepted when in_valid & in_ready.
REQ-012 add_a, add_b  out  DATA_PATH_BITWIDTH  operands to adder; combinational copy of in_a/in_b.
REQ-013 add_en  out  1  low-bit clock-gate enable to adder; registered.
REQ-014 add_c  in  DATA_PATH_BITWIDTH  adder result.
REQ-015 out_valid  out  1  result valid; no backpressure.
REQ-016 out_precise  out  1  mode tag of the current result.
REQ-017 out_c  out  DATA_PATH_BITWIDTH  result.

Function
REQ-018 FSM states SHALL be GATED, SWITCH and PRECISE; add_en SHALL be 1 in SWITCH and PRECISE and 0 in GATED.
REQ-019 in_ready SHALL be 0 in SWITCH, 0 in GATED while in_precise=1, and 1 otherwise.
REQ-020 GATED: in_valid & in_precise SHALL move to SWITCH without accepting; approximate requests SHALL be accepted in place.
REQ-021 SWITCH: a counter SHALL hold the state for exactly SWITCH_CYC cycles, then move to PRECISE; no request accepted meanwhile.
REQ-022 PRECISE: both precise and approximate requests SHALL be accepted.
REQ-023 PRECISE: the idle counter SHALL clear on any accept, otherwise increment, saturating at IDLE_LIMIT.
REQ-024 PRECISE: move to GATED when idle count = IDLE_LIMIT and the tag pipeline is empty; in_valid in that same cycle SHALL win (accept, stay PRECISE).
REQ-025 The tag pipeline SHALL be ADD_LAT stages of {valid, precise}; an accept at cycle t SHALL give out_valid=1 at cycle t+ADD_LAT.
REQ-026 out_c SHALL equal add_c when out_precise=1; otherwise add_c with bits [CLKGATED_BITWIDTH-1:0] forced to 0.
REQ-027 out_valid=0 cycles SHALL drive out_c=0 and out_precise=0.
REQ-028 The adder result is modulo 2^DATA_PATH_BITWIDTH; the block SHALL add no carry-out bit.
REQ-029 Back-to-back accepts SHALL sustain one result per cycle with no bubbles inside one mode.

Reset
REQ-030 rst=1 SHALL force GATED, add_en=0, counters=0, tag pipeline cleared, out_valid=0, out_c=0, out_precise=0.
REQ-031 rst SHALL override all other inputs in the same cycle, including mid-SWITCH and with results in flight; in-flight results SHALL be dropped.
REQ-032 During reset in_ready SHALL be 0; from the first cycle after reset it follows REQ-019.

Verification
REQ-033 Reset, then approximate request a=0x0001_FFFF, b=0x0000_0001 -> in_ready=1, add_en stays 0, out_valid 2 cycles later, out_c=0x0002_0000, out_precise=0.
REQ-034 From GATED, precise request a=0x0000_1234, b=0x0000_0001 held valid -> in_ready=0 for 2 SWITCH cycles, add_en=1 from the first, accept on cycle 3, out_c=0x0000_1235 2 cycles later.
REQ-035 In PRECISE with no requests -> add_en drops after exactly 8 idle cycles; a request in the 8th idle cycle keeps PRECISE.
REQ-036 In PRECISE, 10 alternating precise/approximate requests back-to-back -> 10 consecutive out_valid cycles, tags in order, approximate low 16 bits zero.
REQ-037 rst asserted in the 2nd SWITCH cycle with one approximate result in flight -> next cycle GATED, add_en=0, no out_valid.
REQ-038 a=0xFFFF_FFFF, b=0x0000_0001 precise -> out_c=0x0000_0000, out_valid=1.
